leaf_switch: RTL and testbench

LEAF_SWITCH -- requirements
Module: leaf_switch

---
 rtl/leaf_switch_if.sv | 30 +++
 rtl/leaf_switch.sv | 150 +++++++++++++++
 tb/tb_leaf_switch.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/leaf_switch_if.sv
// Port bundle of the leaf switch: four leaf NI links, the group-router uplink
// and the misroute counter. The "master" modport is the attached environment.
interface leaf_switch_if #(
    parameter int DATA_W = 16
);
    logic [4*DATA_W-1:0] leaf_data_in;
    logic [3:0]          leaf_valid_in;
    logic [3:0]          leaf_ready_out;
    logic [4*DATA_W-1:0] leaf_data_out;
    logic [3:0]          leaf_valid_out;
    logic [DATA_W-1:0]   up_data_in;
    logic                up_valid_in;
    logic                up_ready_out;
    logic [DATA_W-1:0]   up_data_out;
    logic                up_valid_out;
    logic                up_ready_in;
    logic [7:0]          drop_count;

    modport master (
        output leaf_data_in, leaf_valid_in, up_data_in, up_valid_in, up_ready_in,
        input  leaf_ready_out, leaf_data_out, leaf_valid_out,
        input  up_ready_out, up_data_out, up_valid_out, drop_count
    );

    modport slave (
        input  leaf_data_in, leaf_valid_in, up_data_in, up_valid_in, up_ready_in,
        output leaf_ready_out, leaf_data_out, leaf_valid_out,
        output up_ready_out, up_data_out, up_valid_out, drop_count
    );
endinterface

// File: rtl/leaf_switch.sv
// Leaf switch: four leaf ports plus one uplink, 2-deep input FIFOs, per-output
// round-robin arbitration and a saturating counter of misrouted uplink flits.
module leaf_switch #(
    parameter logic [3:0] GROUP_ID = 4'd5,
    parameter int         DATA_W   = 16,
    parameter int         NLEAF    = 4
) (
    input  logic         clk,
    input  logic         reset,
    leaf_switch_if.slave bus
);
    localparam int         NIN    = NLEAF + 1;
    localparam int         UP     = NLEAF;
    localparam logic [2:0] UP_IDX = 3'(UP);

    typedef logic [DATA_W-1:0] flit_t;

    flit_t            fifo_q      [NIN][2];
    logic [NIN-1:0]   wr_ptr_q;
    logic [NIN-1:0]   rd_ptr_q;
    logic [1:0]       cnt_q       [NIN];
    logic [2:0]       rr_q        [NIN];
    logic [2:0]       rr_d        [NIN];
    flit_t            leaf_data_q [NLEAF];
    logic [NLEAF-1:0] leaf_valid_q;
    flit_t            up_data_q;
    logic             up_valid_q;
    logic [7:0]       drop_q;

    flit_t            in_data     [NIN];
    flit_t            head        [NIN];
    logic [NIN-1:0]   in_valid;
    logic [NIN-1:0]   in_ready;
    logic [NIN-1:0]   push;
    logic [NIN-1:0]   pop;
    logic [NIN-1:0]   head_vld;
    logic [NIN-1:0]   drop;
    logic [2:0]       dest        [NIN];
    logic [NIN-1:0]   req         [NIN];
    logic [NIN-1:0]   gnt;
    logic [2:0]       win         [NIN];
    logic             up_free;

    // Accept depends only on the registered count, never on this cycle's pop.
    always_comb begin
        for (int i = 0; i < NLEAF; i++) begin
            in_data[i]  = bus.leaf_data_in[i*DATA_W +: DATA_W];
            in_valid[i] = bus.leaf_valid_in[i];
        end
        in_data[UP]  = bus.up_data_in;
        in_valid[UP] = bus.up_valid_in;
        for (int i = 0; i < NIN; i++) begin
            in_ready[i] = (cnt_q[i] < 2'd2);
            push[i]     = in_valid[i] && in_ready[i];
        end
    end

    always_comb begin
        for (int i = 0; i < NIN; i++) begin
            head[i]     = fifo_q[i][rd_ptr_q[i]];
            head_vld[i] = (cnt_q[i] != 2'd0);
            if (head[i][15:12] == GROUP_ID) dest[i] = {1'b0, head[i][11:10]};
            else                            dest[i] = UP_IDX;
            drop[i] = (i == UP) && head_vld[i] && (head[i][15:12] != GROUP_ID);
        end
        for (int o = 0; o < NIN; o++) begin
            for (int i = 0; i < NIN; i++) begin
                req[o][i] = head_vld[i] && !drop[i] && (dest[i] == 3'(o));
            end
        end
    end

    assign up_free = !up_valid_q || bus.up_ready_in;

    always_comb begin
        int idx;
        idx = 0;
        for (int o = 0; o < NIN; o++) begin
            gnt[o]  = 1'b0;
            win[o]  = 3'd0;
            rr_d[o] = rr_q[o];
            if (o != UP || up_free) begin
                // scan from the far end so the requester nearest the pointer wins
                for (int k = NIN - 1; k >= 0; k--) begin
                    idx = int'(rr_q[o]) + k;
                    if (idx >= NIN) idx = idx - NIN;
                    if (req[o][idx]) begin
                        gnt[o] = 1'b1;
                        win[o] = 3'(idx);
                    end
                end
            end
            if (gnt[o]) rr_d[o] = (win[o] == UP_IDX) ? 3'd0 : win[o] + 3'd1;
        end
        for (int i = 0; i < NIN; i++) begin
            pop[i] = drop[i];
            for (int o = 0; o < NIN; o++) begin
                if (gnt[o] && win[o] == 3'(i)) pop[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NIN; i++) begin
                fifo_q[i][0] <= '0;
                fifo_q[i][1] <= '0;
                cnt_q[i]     <= '0;
                rr_q[i]      <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int o = 0; o < NLEAF; o++) leaf_data_q[o] <= '0;
            leaf_valid_q <= '0;
            up_data_q    <= '0;
            up_valid_q   <= 1'b0;
            drop_q       <= '0;
        end else begin
            for (int i = 0; i < NIN; i++) begin
                if (push[i]) begin
                    fifo_q[i][wr_ptr_q[i]] <= in_data[i];
                    wr_ptr_q[i]            <= ~wr_ptr_q[i];
                end
                if (pop[i]) rd_ptr_q[i] <= ~rd_ptr_q[i];
                cnt_q[i] <= cnt_q[i] + {1'b0, push[i]} - {1'b0, pop[i]};
                rr_q[i]  <= rr_d[i];
            end
            for (int o = 0; o < NLEAF; o++) begin
                leaf_valid_q[o] <= gnt[o];
                if (gnt[o]) leaf_data_q[o] <= head[win[o]];
            end
            // uplink egress register holds until the group router takes it
            if (up_free) begin
                up_valid_q <= gnt[UP];
                if (gnt[UP]) up_data_q <= head[win[UP]];
            end
            if (drop[UP] && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
        end
    end

    for (genvar o = 0; o < NLEAF; o++) begin : g_leaf_out
        assign bus.leaf_data_out[o*DATA_W +: DATA_W] = leaf_data_q[o];
    end
    assign bus.leaf_valid_out = leaf_valid_q;
    assign bus.leaf_ready_out = in_ready[NLEAF-1:0];
    assign bus.up_ready_out   = in_ready[UP];
    assign bus.up_data_out    = up_data_q;
    assign bus.up_valid_out   = up_valid_q;
    assign bus.drop_count     = drop_q;
endmodule

// File: tb/tb_leaf_switch.sv
// Directed bench for leaf_switch: a routing vector table plus hand-written
// sequences for uplink stall, backpressure, arbitration order, drops and reset.
module tb_leaf_switch;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    leaf_switch_if #(.DATA_W(16)) bus ();

    leaf_switch #(.GROUP_ID(4'd5), .DATA_W(16), .NLEAF(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [4:0] vobs;
    assign vobs = {bus.leaf_valid_out, bus.up_valid_out};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_in();
        bus.leaf_valid_in = '0;
        bus.leaf_data_in  = '0;
        bus.up_valid_in   = 1'b0;
        bus.up_data_in    = '0;
    endtask

    task automatic drive(input int src, input logic [15:0] f);
        if (src < 4) begin
            bus.leaf_valid_in[src]        = 1'b1;
            bus.leaf_data_in[src*16 +: 16] = f;
        end else begin
            bus.up_valid_in = 1'b1;
            bus.up_data_in  = f;
        end
    endtask

    // port: 0-3 leaf output, 4 uplink, 5 dropped
    typedef struct {
        int          src;
        logic [15:0] flit;
        int          port;
        logic [7:0]  drops;
    } vec_t;

    vec_t vecs [10];

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, got, n;
        logic acc;
        logic [4:0] exp_v;
        logic [4:0] seen;

        vecs[0] = '{0, 16'h5455, 1, 8'd0};
        vecs[1] = '{1, 16'h5000, 0, 8'd0};
        vecs[2] = '{2, 16'h5C3F, 3, 8'd0};
        vecs[3] = '{3, 16'h5BFF, 2, 8'd0};
        vecs[4] = '{2, 16'h5800, 2, 8'd0};
        vecs[5] = '{2, 16'h8C01, 4, 8'd0};
        vecs[6] = '{4, 16'h5701, 1, 8'd0};
        vecs[7] = '{4, 16'h3000, 5, 8'd1};
        vecs[8] = '{0, 16'hF123, 4, 8'd1};
        vecs[9] = '{4, 16'hA000, 5, 8'd2};

        reset = 1'b0;
        clear_in();
        bus.up_ready_in = 1'b1;
        #1;
        chk("rst_valids", 64'(vobs), 64'd0);
        chk("rst_leaf_data", 64'(bus.leaf_data_out), 64'd0);
        chk("rst_up_data", 64'(bus.up_data_out), 64'd0);
        chk("rst_drop", 64'(bus.drop_count), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_leaf_ready", 64'(bus.leaf_ready_out), 64'hF);
        chk("rst_up_ready", 64'(bus.up_ready_out), 64'd1);

        for (int v = 0; v < 10; v++) begin
            clear_in();
            drive(vecs[v].src, vecs[v].flit);
            @(negedge clk);
            clear_in();
            chk($sformatf("vec%0d_early", v), 64'(vobs), 64'd0);
            @(negedge clk);
            if (vecs[v].port < 4)       exp_v = 5'(1 << (vecs[v].port + 1));
            else if (vecs[v].port == 4) exp_v = 5'd1;
            else                        exp_v = 5'd0;
            chk($sformatf("vec%0d_valid", v), 64'(vobs), 64'(exp_v));
            if (vecs[v].port < 4)
                chk($sformatf("vec%0d_data", v),
                    64'(bus.leaf_data_out[vecs[v].port*16 +: 16]), 64'(vecs[v].flit));
            else if (vecs[v].port == 4)
                chk($sformatf("vec%0d_data", v), 64'(bus.up_data_out), 64'(vecs[v].flit));
            @(negedge clk);
            chk($sformatf("vec%0d_strobe_end", v), 64'(vobs), 64'd0);
            chk($sformatf("vec%0d_drops", v), 64'(bus.drop_count), 64'(vecs[v].drops));
        end

        // uplink egress held while the group router is not ready
        clear_in();
        bus.up_ready_in = 1'b0;
        drive(2, 16'h8C01);
        @(negedge clk);
        clear_in();
        for (int h = 0; h < 3; h++) begin
            @(negedge clk);
            chk($sformatf("hold%0d_valid", h), 64'(bus.up_valid_out), 64'd1);
            chk($sformatf("hold%0d_data", h), 64'(bus.up_data_out), 64'h8C01);
        end
        bus.up_ready_in = 1'b1;
        @(negedge clk);
        chk("hold_release", 64'(vobs), 64'd0);

        // leaf1 backpressure with the uplink stalled, then lossless drain
        clear_in();
        bus.up_ready_in = 1'b0;
        sent = 0;
        got  = 0;
        drive(1, 16'h8001);
        for (int c = 0; c < 30; c++) begin
            if (c == 5) begin
                chk("bp_accepted", 64'(sent), 64'd3);
                chk("bp_ready1", 64'(bus.leaf_ready_out[1]), 64'd0);
                chk("bp_up_valid", 64'(bus.up_valid_out), 64'd1);
                chk("bp_up_data", 64'(bus.up_data_out), 64'h8001);
                bus.up_ready_in = 1'b1;
            end
            acc = bus.leaf_valid_in[1] && bus.leaf_ready_out[1];
            if (bus.up_valid_out && bus.up_ready_in) begin
                chk($sformatf("bp_order%0d", got), 64'(bus.up_data_out), 64'(16'h8001 + 16'(got)));
                got++;
            end
            @(posedge clk);
            #1;
            if (acc) begin
                sent++;
                if (sent < 4) drive(1, 16'(16'h8001 + 16'(sent)));
                else          clear_in();
            end
            @(negedge clk);
        end
        chk("bp_sent", 64'(sent), 64'd4);
        chk("bp_got", 64'(got), 64'd4);

        // misrouted uplink flits: single drop, then saturation
        clear_in();
        drive(4, 16'h3000);
        @(negedge clk);
        clear_in();
        @(negedge clk);
        chk("drop_one_count", 64'(bus.drop_count), 64'd3);
        chk("drop_one_novalid", 64'(vobs), 64'd0);
        drive(4, 16'h3000);
        n = 0;
        for (int c = 0; c < 400 && n < 300; c++) begin
            if (bus.up_ready_out) n++;
            @(negedge clk);
        end
        clear_in();
        chk("sat_accepted", 64'(n), 64'd300);
        repeat (4) @(negedge clk);
        chk("sat_count", 64'(bus.drop_count), 64'd255);
        chk("sat_novalid", 64'(vobs), 64'd0);

        // reset asserted with full FIFOs and a stalled uplink
        bus.up_ready_in = 1'b0;
        for (int i = 0; i < 4; i++) drive(i, 16'(16'h8000 + 16'(i)));
        repeat (4) @(negedge clk);
        chk("pre_rst_up_valid", 64'(bus.up_valid_out), 64'd1);
        chk("pre_rst_ready", 64'(bus.leaf_ready_out), 64'd0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("midrst_valids", 64'(vobs), 64'd0);
        chk("midrst_drop", 64'(bus.drop_count), 64'd0);
        chk("midrst_up_data", 64'(bus.up_data_out), 64'd0);
        @(negedge clk);
        clear_in();
        bus.up_ready_in = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        chk("postrst_leaf_ready", 64'(bus.leaf_ready_out), 64'hF);
        chk("postrst_up_ready", 64'(bus.up_ready_out), 64'd1);
        seen = '0;
        repeat (5) begin
            seen = seen | vobs;
            @(negedge clk);
        end
        chk("postrst_quiet", 64'(seen), 64'd0);
        chk("postrst_drop", 64'(bus.drop_count), 64'd0);

        // four leaves contend for leaf0 every cycle
        for (int i = 0; i < 4; i++) drive(i, 16'(16'h5000 + 16'(i)));
        @(negedge clk);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk($sformatf("rr%0d_valid", k), 64'(bus.leaf_valid_out), 64'h1);
            chk($sformatf("rr%0d_src", k), 64'(bus.leaf_data_out[15:0]), 64'(16'h5000 + 16'(k % 4)));
        end
        clear_in();
        repeat (8) @(negedge clk);
        chk("final_quiet", 64'(vobs), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
